adder_exhaustive_checker: RTL and testbench

Synthesizable stimulus-and-check engine that drives the opposite end of the adder interface. It supplies operands `a`/`b` to an adder under test (the `half_adder` when `WIDTH=1`), waits for the outputs to settle, and samples `sum`/`carry`. Each sample is compared against the arithmetic sum. One `start` runs every operand combination exhaustively. Results are reported as pass/fail, an error count and the first failing vector, so the adder can be self-checked on silicon/FPGA or instantiated inside a test bench.

---
 rtl/adder_check_pkg.sv | 19 +
 rtl/vector_sequencer.sv | 40 ++++
 rtl/adder_exhaustive_checker.sv | 114 +++++++++++
 tb/tb_adder_exhaustive_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_check_pkg.sv
// Shared types and reference arithmetic for the adder exhaustive checker.
package adder_check_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Expected {carry,sum} at full precision; callers zero-extend operands to MAX_W.
    function automatic logic [MAX_W:0] expected_sum(input logic [MAX_W-1:0] x,
                                                    input logic [MAX_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/vector_sequencer.sv
// Vector index and settle-time counter for the exhaustive adder checker.
module vector_sequencer
    import adder_check_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               tick,
    input  logic               step,
    output logic [2*WIDTH-1:0] v,
    output logic               settle_done,
    output logic               last
);

    localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            cnt <= '0;
        end else if (clear) begin
            v   <= '0;
            cnt <= CW'(SETTLE_CYCLES);
        end else if (step) begin
            v   <= v + 1'b1;
            cnt <= CW'(SETTLE_CYCLES);
        end else if (tick) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign settle_done = (cnt <= CW'(1));
    assign last        = &v;

endmodule

// File: rtl/adder_exhaustive_checker.sv
// Exhaustive stimulus-and-check engine for an adder: drives every a/b pair and compares {carry,sum}.
module adder_exhaustive_checker
    import adder_check_pkg::*;
#(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    state_t state, next;
    logic   clear, tick, step, check;
    logic   settle_done, last, mismatch;
    logic [2*WIDTH-1:0] v;

    vector_sequencer #(
        .WIDTH        (WIDTH),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .tick       (tick),
        .step       (step),
        .v          (v),
        .settle_done(settle_done),
        .last       (last)
    );

    // Operands come straight from the registered vector index.
    assign a = v[2*WIDTH-1:WIDTH];
    assign b = v[WIDTH-1:0];

    assign mismatch = ((MAX_W + 1)'({carry, sum}) != expected_sum(MAX_W'(a), MAX_W'(b)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next;
    end

    always_comb begin
        next  = state;
        clear = 1'b0;
        tick  = 1'b0;
        step  = 1'b0;
        check = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear = 1'b1;
                    next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tick = 1'b1;
                if (settle_done) next = ST_CHECK;
            end
            ST_CHECK: begin
                check = 1'b1;
                if (last) begin
                    next = ST_DONE;
                end else begin
                    step = 1'b1;
                    next = ST_SETTLE;
                end
            end
            default: next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass         <= 1'b0;
            err_count    <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else if (clear) begin
            pass         <= 1'b0;
            err_count    <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else if (check) begin
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!fail_seen) begin
                    fail_seen    <= 1'b1;
                    first_fail_a <= a;
                    first_fail_b <= b;
                end
            end
            if (last) pass <= !(fail_seen || mismatch);
        end
    end

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench: drives the checker against table-defined (correct or faulty) adders and checks results.
module tb_adder_exhaustive_checker;

    logic clk = 1'b0;
    logic rst_n, start1, start2;

    logic       a1, b1, sum1, carry1, busy1, done1, pass1, fs1, ffa1, ffb1;
    logic [7:0] err1;
    logic [1:0] a2, b2, sum2, ffa2, ffb2;
    logic       carry2, busy2, done2, pass2, fs2;
    logic [2:0] err2;

    // Adders under test: response tables indexed by {a,b}.
    logic [1:0] tab1 [4];
    logic [2:0] tab2 [16];
    assign {carry1, sum1} = tab1[{a1, b1}];
    assign {carry2, sum2} = tab2[{a2, b2}];

    int total = 0;
    int bad   = 0;

    int   m_pref [16];
    int   m_errs;
    bit   m_fs;
    int   m_fa, m_fb;

    always #5 clk = ~clk;

    adder_exhaustive_checker #(.WIDTH(1), .SETTLE_CYCLES(1), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .sum(sum1), .carry(carry1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_seen(fs1),
        .first_fail_a(ffa1), .first_fail_b(ffb1)
    );

    adder_exhaustive_checker #(.WIDTH(2), .SETTLE_CYCLES(3), .ERR_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .sum(sum2), .carry(carry2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_seen(fs2),
        .first_fail_a(ffa2), .first_fail_b(ffb2)
    );

    // Reference: walk all (a,b) pairs, compare table output with true a+b.
    task automatic model(input int w, input int errmax);
        int n, av, bv, got;
        n = 1 << (2 * w);
        m_errs = 0; m_fs = 0; m_fa = 0; m_fb = 0;
        for (int v = 0; v < n; v++) begin
            av  = v >> w;
            bv  = v & ((1 << w) - 1);
            got = (w == 1) ? int'(tab1[v]) : int'(tab2[v]);
            if (got != av + bv) begin
                if (m_errs < errmax) m_errs++;
                if (!m_fs) begin m_fs = 1; m_fa = av; m_fb = bv; end
            end
            m_pref[v] = m_errs;
        end
    endtask

    task automatic run1(input logic [8:0] mask);
        int k, dedge;
        model(1, 255);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy1, done1, pass1, err1, fs1, ffa1, ffb1, a1, b1} !== {1'b1, 15'b0}) begin
            bad++;
            $display("FAIL run1_edge0: got busy=%b done=%b pass=%b err=%0d fs=%b ff=%b%b ab=%b%b want busy=1 rest 0",
                     busy1, done1, pass1, err1, fs1, ffa1, ffb1, a1, b1);
        end
        k = 0; dedge = -1;
        while (dedge < 0 && k < 40) begin
            @(negedge clk); start1 = (k + 1 < 9) ? mask[k+1] : 1'b0;
            @(posedge clk); #1;
            k++;
            if (done1) begin
                dedge = k;
                total++;
                if (busy1 !== 1'b0) begin bad++; $display("FAIL run1_busy_fall: got %b want 0", busy1); end
            end else if (k < 8) begin
                total++;
                if (busy1 !== 1'b1 || {a1, b1} !== 2'(k / 2)) begin
                    bad++;
                    $display("FAIL run1_vector edge %0d: got busy=%b ab=%b%b want busy=1 ab=%0d", k, busy1, a1, b1, k / 2);
                end
            end
            if (k % 2 == 0 && k <= 8) begin
                total++;
                if (err1 !== 8'(m_pref[k/2-1])) begin
                    bad++; $display("FAIL run1_err_prefix edge %0d: got %0d want %0d", k, err1, m_pref[k/2-1]);
                end
            end
        end
        start1 = 1'b0;
        total++;
        if (dedge != 8) begin bad++; $display("FAIL run1_done_edge: got %0d want 8", dedge); end
        total++;
        if (pass1 !== (m_errs == 0) || err1 !== 8'(m_errs) || fs1 !== m_fs ||
            ffa1 !== 1'(m_fa) || ffb1 !== 1'(m_fb) || {a1, b1} !== 2'b11) begin
            bad++;
            $display("FAIL run1_result: got pass=%b err=%0d fs=%b ff=(%b,%b) ab=%b%b want pass=%0d err=%0d fs=%0d ff=(%0d,%0d) ab=11",
                     pass1, err1, fs1, ffa1, ffb1, a1, b1, m_errs == 0, m_errs, m_fs, m_fa, m_fb);
        end
    endtask

    task automatic run2();
        int k, dedge;
        model(2, 7);
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start2 = 1'b0;
        k = 0; dedge = -1;
        while (dedge < 0 && k < 100) begin
            if (k > 0) @(negedge clk);
            @(posedge clk); #1;
            k++;
            if (done2) dedge = k;
            else if (k < 64) begin
                total++;
                if (busy2 !== 1'b1 || {a2, b2} !== 4'(k / 4)) begin
                    bad++; $display("FAIL run2_vector edge %0d: got busy=%b ab=%h want busy=1 ab=%0d", k, busy2, {a2, b2}, k / 4);
                end
            end
            if (k % 4 == 0 && k <= 64) begin
                total++;
                if (err2 !== 3'(m_pref[k/4-1])) begin
                    bad++; $display("FAIL run2_err_prefix edge %0d: got %0d want %0d", k, err2, m_pref[k/4-1]);
                end
            end
        end
        total++;
        if (dedge != 64) begin bad++; $display("FAIL run2_done_edge: got %0d want 64", dedge); end
        total++;
        if (busy2 !== 1'b0 || pass2 !== (m_errs == 0) || err2 !== 3'(m_errs) || fs2 !== m_fs ||
            ffa2 !== 2'(m_fa) || ffb2 !== 2'(m_fb)) begin
            bad++;
            $display("FAIL run2_result: got busy=%b pass=%b err=%0d fs=%b ff=(%0d,%0d) want busy=0 pass=%0d err=%0d fs=%0d ff=(%0d,%0d)",
                     busy2, pass2, err2, fs2, ffa2, ffb2, m_errs == 0, m_errs, m_fs, m_fa, m_fb);
        end
    endtask

    task automatic set_tab1(input int mode);
        int av, bv;
        for (int v = 0; v < 4; v++) begin
            av = v >> 1; bv = v & 1;
            case (mode)
                0: tab1[v] = 2'(av + bv);
                1: tab1[v] = {1'b0, 1'(av ^ bv)};
                2: tab1[v] = {1'(av & bv), 1'(av | bv)};
                3: tab1[v] = {~1'(av & bv), 1'(av | bv)};
                default: tab1[v] = ($urandom_range(0, 1) == 0) ? 2'(av + bv) : 2'($urandom_range(0, 3));
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        set_tab1(0);
        for (int v = 0; v < 16; v++) tab2[v] = 3'((v >> 2) + (v & 3));
        repeat (2) @(posedge clk); #1;
        total++;
        if ({a1, b1, busy1, done1, pass1, err1, fs1, ffa1, ffb1} !== '0 ||
            {a2, b2, busy2, done2, pass2, err2, fs2, ffa2, ffb2} !== '0) begin
            bad++; $display("FAIL reset_outputs: got dut1 err=%0d busy=%b dut2 err=%0d busy=%b want all 0", err1, busy1, err2, busy2);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_half_adder();      set_tab1(0); run1(9'd0); endtask
    task automatic test_carry_stuck();     set_tab1(1); run1(9'd0); endtask
    task automatic test_sum_or();          set_tab1(2); run1(9'd0); endtask
    task automatic test_sum_or_carry_inv(); set_tab1(3); run1(9'd0); endtask

    task automatic test_reset_mid_run();
        set_tab1(0);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk);
        @(negedge clk); start1 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({a1, b1, busy1, done1, pass1, err1, fs1, ffa1, ffb1} !== '0) begin
            bad++; $display("FAIL reset_mid_run: got ab=%b%b busy=%b done=%b want all 0", a1, b1, busy1, done1);
        end
        @(negedge clk); rst_n = 1'b1;
        run1(9'd0);
    endtask

    task automatic test_start_while_busy(); set_tab1(2); run1(9'b000100100); endtask

    task automatic test_back_to_back();
        set_tab1(3); run1(9'd0);
        set_tab1(0); run1(9'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            set_tab1(4);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run1(9'($urandom) & 9'h0FE);
        end
    endtask

    task automatic test_wide();
        for (int v = 0; v < 16; v++) tab2[v] = 3'd0;
        run2();
        for (int v = 0; v < 16; v++)
            tab2[v] = ($urandom_range(0, 3) != 0) ? 3'((v >> 2) + (v & 3)) : 3'($urandom_range(0, 7));
        run2();
    endtask

    initial begin
        test_reset();
        test_half_adder();
        test_carry_stuck();
        test_sum_or();
        test_sum_or_carry_inv();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
